// File: rtl/sda_link_pkg.sv
// Shared definitions for the two-wire sda link (transmitter and receiver).
package sda_link_pkg;

  localparam int unsigned HALF_DEFAULT   = 2;
  localparam int unsigned DATA_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    ACK,
    STOP
  } sda_state_e;

  // Cycles from the first START cycle to the done pulse.
  function automatic int unsigned xfer_cycles(input int unsigned half,
                                              input int unsigned data_w);
    return (2 * data_w + 5) * half;
  endfunction

endpackage

// File: rtl/sda_half_tick.sv
// Half-period timer: counts 0..HALF-1 and strobes phase_end on the last count.
module sda_half_tick import sda_link_pkg::*; #(
  parameter int unsigned HALF = HALF_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic phase_end
);

  localparam int unsigned   CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign phase_end = !clear && (cnt_q == LAST);

  // Next count: hold at zero while cleared, wrap after the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sda_byte_tx.sv
// Controller-side sda transmitter: start, MSB-first data, ack slot, stop.
module sda_byte_tx import sda_link_pkg::*; #(
  parameter int unsigned HALF   = HALF_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  inout  wire               sda,
  output logic              oe,
  output logic              scl,
  output logic              busy,
  output logic              done,
  output logic              ack_ok
);

  localparam int unsigned   BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  sda_state_e        state_q,   state_d;
  logic              phase_q,   phase_d;   // 0: scl low half, 1: scl high half
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q,   shreg_d;
  logic              oe_q,      oe_d;
  logic              sda_r_q,   sda_r_d;
  logic              scl_q,     scl_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              ack_smp_q, ack_smp_d;
  logic              ack_ok_q,  ack_ok_d;
  logic              phase_end;

  sda_half_tick #(.HALF(HALF)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_q == IDLE),
    .phase_end (phase_end)
  );

  assign sda    = oe_q ? sda_r_q : 1'bz;
  assign oe     = oe_q;
  assign scl    = scl_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign ack_ok = ack_ok_q;

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    oe_d      = oe_q;
    sda_r_d   = sda_r_q;
    scl_d     = scl_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_smp_d = ack_smp_q;
    ack_ok_d  = ack_ok_q;
    unique case (state_q)
      IDLE: begin
        // The done cycle is still IDLE; a start seen there is not taken.
        if (start && !done_q) begin
          shreg_d   = din;
          bit_cnt_d = '0;
          phase_d   = 1'b0;
          state_d   = START;
          oe_d      = 1'b1;
          sda_r_d   = 1'b0;
          scl_d     = 1'b1;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (phase_end) begin
          state_d = DATA;
          phase_d = 1'b0;
          scl_d   = 1'b0;
          sda_r_d = shreg_q[DATA_W-1];
        end
      end
      DATA: begin
        if (phase_end) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            scl_d   = 1'b1;
          end else begin
            shreg_d = shreg_q << 1;
            phase_d = 1'b0;
            scl_d   = 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              state_d   = ACK;
              bit_cnt_d = '0;
              oe_d      = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              sda_r_d   = shreg_d[DATA_W-1];
            end
          end
        end
      end
      ACK: begin
        if (phase_end) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            scl_d   = 1'b1;
          end else begin
            // Only a solid 0 counts as an ack; z/x fall to the else branch.
            if (sda == 1'b0) begin
              ack_smp_d = 1'b1;
            end else begin
              ack_smp_d = 1'b0;
            end
            state_d = STOP;
            phase_d = 1'b0;
            scl_d   = 1'b0;
            oe_d    = 1'b1;
            sda_r_d = 1'b0;
          end
        end
      end
      STOP: begin
        if (phase_end) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            scl_d   = 1'b1;
          end else begin
            state_d  = IDLE;
            phase_d  = 1'b0;
            oe_d     = 1'b0;
            sda_r_d  = 1'b1;
            scl_d    = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            ack_ok_d = ack_smp_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, shifter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      oe_q      <= 1'b0;
      sda_r_q   <= 1'b1;
      scl_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_smp_q <= 1'b0;
      ack_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      oe_q      <= oe_d;
      sda_r_q   <= sda_r_d;
      scl_q     <= scl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_smp_q <= ack_smp_d;
      ack_ok_q  <= ack_ok_d;
    end
  end

endmodule
